// File: rtl/conv_block.sv
// ---------------------------------------------------------------------------
// conv_block
//
// Streaming 2-D convolution engine for a single feature-map channel.
// A KERNEL_SIZE x KERNEL_SIZE set of signed weights is loaded once after
// power-up. The block then accepts a square feature map one pixel per clock
// in row-major order and emits one 48-bit signed result per fully-inside,
// stride-aligned window, also in row-major order.
//
// Ports
//   i_clk          rising-edge clock for all logic
//   i_rst          synchronous active-high reset (does not touch weights)
//   i_go           start level; IDLE->RUN when sampled high, DONE->IDLE
//                  when sampled low
//   i_fm_data      30-bit signed feature-map pixel, one per clock in RUN
//   i_weight_data  18-bit signed kernel weight, streamed after power-up
//   o_en           one-cycle strobe marking o_conv_result valid
//   o_conv_result  48-bit signed convolution result (wraps modulo 2^48)
//
// Pipeline (T = edge that samples pixel p)
//   T    pixel captured with its window-valid tag
//   T+1  line buffers and window register shift; window complete
//   T+2  K*K products registered
//   T+3  adder tree result registered into o_conv_result, o_en raised
// ---------------------------------------------------------------------------
module conv_block #(
  parameter int KERNEL_SIZE = 3,
  parameter int FM_SIZE     = 252,
  parameter int PADDING     = 0,
  parameter int STRIDE      = 1,
  parameter int MAXPOOL     = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_go,
  input  logic [29:0] i_fm_data,
  input  logic [17:0] i_weight_data,
  output logic        o_en,
  output logic [47:0] o_conv_result
);

  localparam int K        = KERNEL_SIZE;
  localparam int N        = FM_SIZE;
  localparam int S        = STRIDE;
  localparam int KK       = K * K;
  localparam int OUT_SIZE = ((N - K + 2 * PADDING) / S) + 1;
  localparam int TOTAL    = OUT_SIZE * OUT_SIZE;
  localparam int CW       = $clog2(N);
  localparam int PW       = (S > 1) ? $clog2(S) : 1;
  localparam int LW       = $clog2(KK + 3);
  localparam int RW       = $clog2(TOTAL + 1);

  // Unsupported configurations are rejected at elaboration.
  if (PADDING != 0) begin : g_bad_padding
    $error("conv_block: PADDING must be 0");
  end
  if (MAXPOOL != 0) begin : g_bad_maxpool
    $error("conv_block: MAXPOOL must be 0");
  end
  if (K < 2) begin : g_bad_kernel
    $error("conv_block: KERNEL_SIZE must be at least 2");
  end
  if (N < K) begin : g_bad_fm_size
    $error("conv_block: FM_SIZE must be at least KERNEL_SIZE");
  end
  if (S < 1) begin : g_bad_stride
    $error("conv_block: STRIDE must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t state;

  // -------------------------------------------------------------------------
  // Weight load. The counter's power-up value is its only initialisation:
  // reset must not disturb the loaded kernel. Counter value c at an edge
  // means c edges have already passed, so the word driven after edge n sits
  // in w_in when the counter reads n+1, and lands in weight slot n-1.
  // -------------------------------------------------------------------------
  logic signed [17:0] w_in;
  logic signed [17:0] wgt [KK];
  logic [LW-1:0]      ld_cnt = '0;

  always_ff @(posedge i_clk) begin
    w_in <= i_weight_data;
    if (ld_cnt != LW'(KK + 2)) begin
      ld_cnt <= ld_cnt + LW'(1);
    end
    for (int w = 0; w < KK; w++) begin
      if (ld_cnt == LW'(w + 2)) begin
        wgt[w] <= w_in;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Run control and pixel capture.
  // row/col track the pixel being sampled this edge. The phase counters hold
  // (position - (K-1)) mod S once the position reaches K-1, so a window whose
  // bottom-right pixel lands here is emitted only when both phases are zero;
  // this also rejects windows that would wrap across a row boundary.
  // -------------------------------------------------------------------------
  logic [CW-1:0]      row_cnt;
  logic [CW-1:0]      col_cnt;
  logic [PW-1:0]      row_ph;
  logic [PW-1:0]      col_ph;
  logic [RW-1:0]      res_cnt;
  logic [29:0]        fm_reg;
  logic               px_vld;
  logic               px_ok;
  logic               win_ok;
  logic               mul_vld;

  function automatic logic [PW-1:0] next_ph(input logic [CW-1:0] cnt,
                                            input logic [PW-1:0] ph);
    if (cnt < CW'(K - 1)) begin
      return '0;
    end else if (ph == PW'(S - 1)) begin
      return '0;
    end else begin
      return ph + PW'(1);
    end
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      row_cnt <= '0;
      col_cnt <= '0;
      row_ph  <= '0;
      col_ph  <= '0;
      res_cnt <= '0;
      px_vld  <= 1'b0;
      px_ok   <= 1'b0;
    end else begin
      px_vld <= 1'b0;
      px_ok  <= 1'b0;
      if (mul_vld && (res_cnt != RW'(TOTAL))) begin
        res_cnt <= res_cnt + RW'(1);
      end
      case (state)
        IDLE: begin
          if (i_go) begin
            state   <= RUN;
            row_cnt <= '0;
            col_cnt <= '0;
            row_ph  <= '0;
            col_ph  <= '0;
            res_cnt <= '0;
          end
        end
        RUN: begin
          fm_reg <= i_fm_data;
          px_vld <= 1'b1;
          px_ok  <= (row_cnt >= CW'(K - 1)) && (col_cnt >= CW'(K - 1)) &&
                    (row_ph == '0) && (col_ph == '0);
          if (col_cnt == CW'(N - 1)) begin
            col_cnt <= '0;
            col_ph  <= '0;
            if (row_cnt == CW'(N - 1)) begin
              state <= FLUSH;
            end else begin
              row_cnt <= row_cnt + CW'(1);
              row_ph  <= next_ph(row_cnt, row_ph);
            end
          end else begin
            col_cnt <= col_cnt + CW'(1);
            col_ph  <= next_ph(col_cnt, col_ph);
          end
        end
        FLUSH: begin
          // With a large stride the final result may already be out.
          if ((res_cnt == RW'(TOTAL)) ||
              (mul_vld && (res_cnt == RW'(TOTAL - 1)))) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!i_go) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Line buffers as circular RAMs: the word read at the pointer was written
  // exactly N pushes earlier, i.e. the pixel one row above. Buffer k feeds
  // buffer k+1, so buffer k delivers the pixel k+1 rows above.
  // -------------------------------------------------------------------------
  logic [29:0]        lb_mem [K-1][N];
  logic [29:0]        lb_rd  [K-1];
  logic [CW-1:0]      lb_ptr;
  logic signed [29:0] win [K][K];

  always_comb begin
    for (int k = 0; k < K - 1; k++) begin
      lb_rd[k] = lb_mem[k][lb_ptr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lb_ptr <= '0;
    end else if (px_vld) begin
      lb_ptr <= (lb_ptr == CW'(N - 1)) ? '0 : lb_ptr + CW'(1);
    end
  end

  // Window column j = K-1 is the newest column; row K-1 is the current row.
  always_ff @(posedge i_clk) begin
    if (px_vld) begin
      lb_mem[0][lb_ptr] <= fm_reg;
      for (int k = 1; k < K - 1; k++) begin
        lb_mem[k][lb_ptr] <= lb_rd[k-1];
      end
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) begin
          win[i][j] <= win[i][j+1];
        end
      end
      win[K-1][K-1] <= fm_reg;
      for (int i = 0; i < K - 1; i++) begin
        win[i][K-1] <= lb_rd[K-2-i];
      end
    end
  end

  // Valid tags travel alongside the data and are the only pipeline state
  // that reset has to clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      win_ok  <= 1'b0;
      mul_vld <= 1'b0;
    end else begin
      win_ok  <= px_vld & px_ok;
      mul_vld <= win_ok;
    end
  end

  // -------------------------------------------------------------------------
  // Multipliers and adder tree. Operands are sign-extended to 48 bits first,
  // so the products and the sum wrap modulo 2^48 with no saturation.
  // -------------------------------------------------------------------------
  logic signed [47:0] prod [KK];
  logic [47:0]        sum;

  always_ff @(posedge i_clk) begin
    if (win_ok) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          prod[i*K+j] <= 48'(win[i][j]) * 48'(wgt[i*K+j]);
        end
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int w = 0; w < KK; w++) begin
      sum = sum + prod[w];
    end
  end

  // Result register holds its value between strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_en          <= 1'b0;
      o_conv_result <= '0;
    end else begin
      o_en <= mul_vld;
      if (mul_vld) begin
        o_conv_result <= sum;
      end
    end
  end

endmodule

// File: tb/tb_conv_block.sv
// ---------------------------------------------------------------------------
// tb_conv_block
//
// Five conv_block instances share clock, reset and the pixel bus; each gets
// its own weight stream (weights load only once after power-up) and its own
// i_go. Expected results come from a direct evaluation of the convolution
// sum over the stored pixel array, with the expected output edge derived
// from the window's bottom-right pixel index.
//   idx0  N=5  S=1  weights all 1
//   idx1  N=5  S=1  centre weight 1
//   idx2  N=5  S=1  weights all 2
//   idx3  N=5  S=2  weights all 1
//   idx4  defaults (N=252, S=1), random weights
// ---------------------------------------------------------------------------
module tb_conv_block;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        go   [5];
  logic [29:0] fm;
  logic [17:0] wbus [5];
  logic        en   [5];
  logic [47:0] res  [5];

  always #5 i_clk = ~i_clk;

  int edge_cnt = 0;
  always @(posedge i_clk) edge_cnt <= edge_cnt + 1;

  conv_block #(.KERNEL_SIZE(3), .FM_SIZE(5), .PADDING(0), .STRIDE(1), .MAXPOOL(0)) u_ones (
    .i_clk(i_clk), .i_rst(i_rst), .i_go(go[0]), .i_fm_data(fm),
    .i_weight_data(wbus[0]), .o_en(en[0]), .o_conv_result(res[0]));

  conv_block #(.KERNEL_SIZE(3), .FM_SIZE(5), .PADDING(0), .STRIDE(1), .MAXPOOL(0)) u_centre (
    .i_clk(i_clk), .i_rst(i_rst), .i_go(go[1]), .i_fm_data(fm),
    .i_weight_data(wbus[1]), .o_en(en[1]), .o_conv_result(res[1]));

  conv_block #(.KERNEL_SIZE(3), .FM_SIZE(5), .PADDING(0), .STRIDE(1), .MAXPOOL(0)) u_neg (
    .i_clk(i_clk), .i_rst(i_rst), .i_go(go[2]), .i_fm_data(fm),
    .i_weight_data(wbus[2]), .o_en(en[2]), .o_conv_result(res[2]));

  conv_block #(.KERNEL_SIZE(3), .FM_SIZE(5), .PADDING(0), .STRIDE(2), .MAXPOOL(0)) u_stride (
    .i_clk(i_clk), .i_rst(i_rst), .i_go(go[3]), .i_fm_data(fm),
    .i_weight_data(wbus[3]), .o_en(en[3]), .o_conv_result(res[3]));

  conv_block u_full (
    .i_clk(i_clk), .i_rst(i_rst), .i_go(go[4]), .i_fm_data(fm),
    .i_weight_data(wbus[4]), .o_en(en[4]), .o_conv_result(res[4]));

  int passed = 0;
  int total  = 0;

  logic [29:0] pix [63504];
  logic [17:0] wts [5][9];

  logic [47:0] got_val [$];
  int          got_off [$];
  logic [47:0] exp_val [$];
  int          exp_off [$];

  int sel   = -1;
  int stray = 0;
  int e0    = 0;

  // Collect strobes of the instance under test; anything else is stray.
  always @(negedge i_clk) begin
    for (int i = 0; i < 5; i++) begin
      if (en[i] === 1'b1) begin
        if (i == sel) begin
          got_val.push_back(res[i]);
          got_off.push_back(edge_cnt - e0);
        end else begin
          stray++;
        end
      end
    end
  end

  // Reference: direct evaluation of the convolution sum for every aligned
  // window, plus the edge (relative to E0) at which it must be registered.
  function automatic void build_expect(input int n, input int k, input int s, input int inst);
    int o;
    longint acc;
    logic [63:0] a;
    exp_val.delete();
    exp_off.delete();
    o = (n - k) / s + 1;
    for (int r = 0; r < o; r++) begin
      for (int c = 0; c < o; c++) begin
        acc = 0;
        for (int i = 0; i < k; i++) begin
          for (int j = 0; j < k; j++) begin
            acc += longint'($signed(wts[inst][i*k+j])) *
                   longint'($signed(pix[(r*s+i)*n + c*s+j]));
          end
        end
        a = acc;
        exp_val.push_back(a[47:0]);
        exp_off.push_back(1 + ((r*s+k-1)*n + (c*s+k-1)) + 3);
      end
    end
  endfunction

  function automatic void fill_ramp();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        pix[r*5+c] = 30'(5*r + c);
  endfunction

  // Pulse go, stream n*n pixels with no gaps; optionally pulse reset for one
  // cycle so that it is sampled one edge after pixel rst_at is driven.
  task automatic start_run(input int inst, input int n, input bit hold, input int rst_at);
    got_val.delete();
    got_off.delete();
    sel = inst;
    @(posedge i_clk); #1;
    go[inst] = 1'b1;
    @(posedge i_clk); #1;
    e0 = edge_cnt;
    fm = pix[0];
    if (!hold) go[inst] = 1'b0;
    for (int p = 1; p < n*n; p++) begin
      @(posedge i_clk); #1;
      fm = pix[p];
      if (p == rst_at) i_rst = 1'b1;
      if (p == rst_at + 1) i_rst = 1'b0;
    end
  endtask

  task automatic wait_results(input int want, input int budget, input int settle);
    for (int c = 0; c < budget; c++) begin
      if (got_val.size() >= want) break;
      @(negedge i_clk);
    end
    repeat (settle) @(negedge i_clk);
  endtask

  // Reset values while the weight streams are being driven.
  task automatic test_reset();
    for (int n = 1; n <= 9; n++) begin
      @(posedge i_clk); #1;
      for (int d = 0; d < 5; d++) wbus[d] = wts[d][n-1];
      @(negedge i_clk);
      if (n == 3) begin
        for (int d = 0; d < 5; d++) begin
          total++;
          if (en[d] !== 1'b0 || res[d] !== 48'd0)
            $display("[TB] FAIL reset[%0d]: o_en=%b result=%h, required o_en=0 result=0", d, en[d], res[d]);
          else passed++;
        end
        i_rst = 1'b0;
      end
    end
    while (edge_cnt < 14) @(posedge i_clk);
  endtask

  task automatic test_ramp_ones();
    logic [47:0] tbl [9];
    tbl = '{48'd54, 48'd63, 48'd72, 48'd99, 48'd108, 48'd117, 48'd144, 48'd153, 48'd162};
    fill_ramp();
    build_expect(5, 3, 1, 0);
    start_run(0, 5, 1'b0, -1);
    wait_results(9, 60, 10);
    total++;
    if (got_val.size() != 9) $display("[TB] FAIL ramp_count: got %0d, required 9", got_val.size());
    else passed++;
    total++;
    if (got_off.size() < 1 || got_off[0] != 16)
      $display("[TB] FAIL ramp_first_latency: got %0d, required 16", (got_off.size() < 1) ? -1 : got_off[0]);
    else passed++;
    for (int i = 0; i < 9; i++) begin
      total++;
      if (i >= got_val.size())
        $display("[TB] FAIL ramp[%0d]: missing, required %0d at +%0d", i, tbl[i], exp_off[i]);
      else if (got_val[i] !== tbl[i] || got_off[i] != exp_off[i])
        $display("[TB] FAIL ramp[%0d]: got %0d at +%0d, required %0d at +%0d", i, got_val[i], got_off[i], tbl[i], exp_off[i]);
      else passed++;
    end
  endtask

  task automatic test_centre();
    logic [47:0] tbl [9];
    tbl = '{48'd6, 48'd7, 48'd8, 48'd11, 48'd12, 48'd13, 48'd16, 48'd17, 48'd18};
    fill_ramp();
    build_expect(5, 3, 1, 1);
    start_run(1, 5, 1'b0, -1);
    wait_results(9, 60, 10);
    total++;
    if (got_val.size() != 9) $display("[TB] FAIL centre_count: got %0d, required 9", got_val.size());
    else passed++;
    for (int i = 0; i < 9; i++) begin
      total++;
      if (i >= got_val.size())
        $display("[TB] FAIL centre[%0d]: missing, required %0d", i, tbl[i]);
      else if (got_val[i] !== tbl[i] || got_off[i] != exp_off[i])
        $display("[TB] FAIL centre[%0d]: got %0d at +%0d, required %0d at +%0d", i, got_val[i], got_off[i], tbl[i], exp_off[i]);
      else passed++;
    end
  endtask

  task automatic test_signed();
    for (int p = 0; p < 25; p++) pix[p] = 30'h3FFFFFFF;
    build_expect(5, 3, 1, 2);
    start_run(2, 5, 1'b0, -1);
    wait_results(9, 60, 10);
    total++;
    if (got_val.size() != 9) $display("[TB] FAIL signed_count: got %0d, required 9", got_val.size());
    else passed++;
    for (int i = 0; i < 9; i++) begin
      total++;
      if (i >= got_val.size())
        $display("[TB] FAIL signed[%0d]: missing, required ffffffffffee", i);
      else if (got_val[i] !== 48'hFFFFFFFFFFEE || got_val[i] !== exp_val[i] || got_off[i] != exp_off[i])
        $display("[TB] FAIL signed[%0d]: got %h at +%0d, required ffffffffffee at +%0d", i, got_val[i], got_off[i], exp_off[i]);
      else passed++;
    end
  endtask

  task automatic test_stride();
    logic [47:0] tbl [4];
    tbl = '{48'd54, 48'd72, 48'd144, 48'd162};
    fill_ramp();
    build_expect(5, 3, 2, 3);
    start_run(3, 5, 1'b0, -1);
    wait_results(4, 60, 10);
    total++;
    if (got_val.size() != 4) $display("[TB] FAIL stride_count: got %0d, required 4", got_val.size());
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= got_val.size())
        $display("[TB] FAIL stride[%0d]: missing, required %0d", i, tbl[i]);
      else if (got_val[i] !== tbl[i] || got_off[i] != exp_off[i])
        $display("[TB] FAIL stride[%0d]: got %0d at +%0d, required %0d at +%0d", i, got_val[i], got_off[i], tbl[i], exp_off[i]);
      else passed++;
    end
  endtask

  // Reset sampled while the first result is one stage from the output.
  task automatic test_reset_mid_run();
    fill_ramp();
    start_run(0, 5, 1'b0, 14);
    wait_results(1, 30, 5);
    total++;
    if (got_val.size() != 0) $display("[TB] FAIL midreset_no_en: got %0d strobes, required 0", got_val.size());
    else passed++;
    total++;
    if (res[0] !== 48'd0) $display("[TB] FAIL midreset_result: got %0d, required 0", res[0]);
    else passed++;
    build_expect(5, 3, 1, 0);
    start_run(0, 5, 1'b0, -1);
    wait_results(9, 60, 10);
    total++;
    if (got_val.size() != 9) $display("[TB] FAIL midreset_rerun_count: got %0d, required 9", got_val.size());
    else passed++;
    for (int i = 0; i < 9; i++) begin
      total++;
      if (i >= got_val.size())
        $display("[TB] FAIL midreset_rerun[%0d]: missing, required %0d", i, exp_val[i]);
      else if (got_val[i] !== exp_val[i] || got_off[i] != exp_off[i])
        $display("[TB] FAIL midreset_rerun[%0d]: got %0d at +%0d, required %0d at +%0d", i, got_val[i], got_off[i], exp_val[i], exp_off[i]);
      else passed++;
    end
  endtask

  // Full-size map with random data and go held high throughout.
  task automatic test_full_random();
    int bad = 0;
    for (int p = 0; p < 252*252; p++) pix[p] = 30'($urandom);
    build_expect(252, 3, 1, 4);
    start_run(4, 252, 1'b1, -1);
    wait_results(62500, 200, 60);
    total++;
    if (got_val.size() != 62500) $display("[TB] FAIL full_count: got %0d, required 62500", got_val.size());
    else passed++;
    for (int i = 0; i < 62500 && i < got_val.size(); i++) begin
      if (got_val[i] !== exp_val[i] || got_off[i] != exp_off[i]) begin
        if (bad < 5)
          $display("[TB]   result %0d: got %h at +%0d, expected %h at +%0d", i, got_val[i], got_off[i], exp_val[i], exp_off[i]);
        bad++;
      end
    end
    total++;
    if (bad != 0) $display("[TB] FAIL full_values: %0d results differ, required 0", bad);
    else passed++;
    go[4] = 1'b0;
    repeat (5) @(negedge i_clk);
  endtask

  task automatic test_no_stray();
    total++;
    if (stray != 0) $display("[TB] FAIL stray_strobes: got %0d, required 0", stray);
    else passed++;
  endtask

  initial begin
    i_rst = 1'b1;
    fm    = '0;
    for (int d = 0; d < 5; d++) begin
      go[d]   = 1'b0;
      wbus[d] = '0;
    end
    for (int w = 0; w < 9; w++) begin
      wts[0][w] = 18'd1;
      wts[1][w] = (w == 4) ? 18'd1 : 18'd0;
      wts[2][w] = 18'd2;
      wts[3][w] = 18'd1;
      wts[4][w] = 18'($urandom);
    end
    $display("[TB] start");
    test_reset();
    test_ramp_ones();
    test_centre();
    test_signed();
    test_stride();
    test_reset_mid_run();
    test_full_random();
    test_no_stray();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/conv_block.md
# conv_block

Streaming 2-D convolution engine (DSP-cascade style) for one feature-map channel. It holds a KERNEL_SIZE×KERNEL_SIZE signed weight set and accepts a square feature map one pixel per clock in row-major order. It emits one 48-bit signed convolution result per valid output window, row-major, with a valid strobe. It sits between the feature-map/weight BRAM readers and the output-feature-map writer.

## Interface
- KERNEL_SIZE, 3, kernel side K (≥2).
- FM_SIZE, 252, input feature-map side N (≥K).
- PADDING, 0, zero padding; only 0 is supported, other values are an elaboration error.
- STRIDE, 1, window stride S (≥1).
- MAXPOOL, 0, reserved; must be 0, other values are an elaboration error.
- OUT_SIZE (localparam), ((N−K+2·PADDING)/S)+1, output side.

Ports:
- i_clk  in  1  single clock, all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_go  in  1  start level; sampled every edge.
- i_fm_data  in  30  feature-map pixel, signed two's complement.
- i_weight_data  in  18  kernel weight, signed two's complement.
- o_en  out  1  one-cycle strobe marking o_conv_result valid.
- o_conv_result  out  48  signed convolution result.

## Operation
- Weight load is independent of i_rst:
  - i_weight_data goes through a one-cycle input register.
  - A load counter (power-up value 0, not cleared by reset) writes weight[n−1] from the word driven just after edge n, for n=1..K².
  - The counter then saturates; weights are held thereafter.
  - Weight index w = i·K+j, where i is the kernel row and j is the kernel column.
- States: IDLE, RUN, FLUSH, DONE.
  - IDLE→RUN on the edge that samples i_go=1. Call this edge E0.
  - In RUN, pixel p (p=0..N²−1, row-major) is sampled at edge E0+1+p, one pixel per cycle with no gaps.
  - RUN→FLUSH after pixel N²−1 is sampled.
  - FLUSH→DONE when the last result has been emitted.
  - DONE→IDLE when i_go is sampled 0. A held-high i_go never restarts a run.
- Datapath:
  - K−1 line buffers of depth N plus a K×K window register.
  - K² signed 30×18 multipliers feeding a cascaded/tree adder.
  - Result(r,c) = Σ_{i,j<K} weight[i·K+j] · x[r·S+i][c·S+j], for r,c in 0..OUT_SIZE−1.
- Arithmetic: products are sign-extended to 48 bits and the sum wraps modulo 2^48, with no saturation.
- Only windows fully inside the map are output. Windows that wrap across a row boundary are never emitted.
- With stride, only windows whose top-left corner satisfies r%S==0 and c%S==0 are emitted.
- Exactly OUT_SIZE² o_en pulses per run, in row-major output order.
- The pixel stream is not back-pressured. i_go falling during RUN is ignored; the run completes.

## Timing
- Reset values:
  - o_en=0, o_conv_result=0, state IDLE.
  - Window and line-buffer contents are don't-care; they are refilled each run.
  - Weights and the load counter are not reset.
- Latency: result(r,c) is registered at edge E0+1+p_last+3, where p_last=(r·S+K−1)·N+(c·S+K−1) is the index of the window's bottom-right pixel. The output is visible in the cycle after that edge, with o_en=1 for exactly that cycle.
- o_conv_result holds its last value while o_en=0.
- Consecutive windows in a row (S=1) produce back-to-back o_en pulses.
- Reset mid-run: reset has priority. It forces the outputs to their reset values and returns to IDLE the next cycle. No further o_en occurs until a new i_go.
- First run after power-up: i_go must not be sampled before edge K²+1.

## Test plan
- N=5, K=3, S=1, weights all 1, x[r][c]=5r+c → 9 outputs, each equal to 9(5r+c)+54. Expected sequence: 54, 63, 72, 99, 108, 117, 144, 153, 162. First o_en follows edge E0+1+12+3.
- N=5, K=3, centre weight (index 4)=1, others 0 → outputs equal x[r+1][c+1], i.e. 6, 7, 8, 11, 12, 13, 16, 17, 18.
- Signed check: all pixels 30'h3FFFFFFF (−1), all weights 2 → every output is 48'hFFFFFFFFFFEE (−18).
- N=5, K=3, S=2, weights all 1, same ramp → exactly 4 outputs: 54, 72, 144, 162.
- Assert i_rst for one cycle midway through RUN → o_en stays 0 and state returns to IDLE. A fresh i_go then yields the full correct 9-result sequence.
- Defaults (N=252, K=3), random data vs a software model → exactly 62500 o_en pulses, all bit-exact. With i_go held high, no second run starts.
